// File: rtl/trojan_resp_capture.sv
// Captures a DUT's response over a fixed window: each sample folds into a MISR
// signature and pushes a {stim, resp} record into a first-word-fall-through FIFO.
module trojan_resp_capture #(
  parameter int OUT_W      = 8,
  parameter int STIM_W     = 3,
  parameter int CAP_CYC    = 16,
  parameter int FIFO_DEPTH = 16,
  parameter logic [OUT_W-1:0] POLY = OUT_W'('h1D)
) (
  input  logic                    CK,
  input  logic                    reset,
  input  logic                    start,
  input  logic [STIM_W-1:0]       stim_in,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [STIM_W+OUT_W-1:0] rec_data,
  output logic [OUT_W-1:0]        sig,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = STIM_W + OUT_W;
  localparam logic [15:0] LAST_SAMPLE = 16'(CAP_CYC - 1);

  if (OUT_W < 2 || OUT_W > 64) begin : g_bad_out_w
    $error("trojan_resp_capture: OUT_W must be 2..64");
  end
  if (STIM_W < 1 || STIM_W > 32) begin : g_bad_stim_w
    $error("trojan_resp_capture: STIM_W must be 1..32");
  end
  if (CAP_CYC < 1 || CAP_CYC > 65535) begin : g_bad_cap_cyc
    $error("trojan_resp_capture: CAP_CYC must be 1..65535");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("trojan_resp_capture: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_reg;
  logic [15:0]      count_reg;
  logic [OUT_W-1:0] sig_reg;
  logic [OUT_W-1:0] misr_next;
  logic             overflow_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  logic fifo_empty;
  logic fifo_full;
  logic sample;
  logic pop;
  logic push_ok;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                      (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign sample     = (state_reg == CAPTURE);
  assign pop        = !fifo_empty && rec_ready;
  // A full FIFO still takes the new record when the head leaves on the same edge.
  assign push_ok    = sample && (!fifo_full || pop);

  // Shift-left MISR with conditional polynomial feedback, one bit per lane.
  genvar gi;
  for (gi = 0; gi < OUT_W; gi++) begin : g_misr
    if (gi == 0) begin : g_lsb
      assign misr_next[gi] = (sig_reg[OUT_W-1] & POLY[gi]) ^ dut_out[gi];
    end else begin : g_upper
      assign misr_next[gi] = sig_reg[gi-1] ^ (sig_reg[OUT_W-1] & POLY[gi]) ^ dut_out[gi];
    end
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      sig_reg      <= '0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg    <= SETTLE;
            count_reg    <= '0;
            sig_reg      <= '0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
          end
        end
        SETTLE: state_reg <= CAPTURE;
        CAPTURE: begin
          sig_reg   <= misr_next;
          count_reg <= count_reg + 16'd1;
          if (!push_ok) overflow_reg <= 1'b1;
          if (count_reg == LAST_SAMPLE) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge CK) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= {stim_in, dut_out};
  end

  assign rec_valid = !fifo_empty;
  assign rec_data  = mem[rd_ptr_reg[AW-1:0]];
  assign sig       = sig_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_trojan_resp_capture.sv
// Bench for trojan_resp_capture: queue-based reference model for a 20-sample
// instance plus directed vectors on 2-sample and 1-sample instances.
module tb_trojan_resp_capture;

  localparam int OW    = 8;
  localparam int SW    = 3;
  localparam int DEPTH = 16;
  localparam int CAP   = 20;
  localparam logic [7:0] POLY = 8'h1D;

  logic CK = 1'b0;
  logic reset = 1'b1;
  always #5 CK = ~CK;

  // main instance
  logic          start = 1'b0;
  logic [SW-1:0] stim_in = '0;
  logic [OW-1:0] dut_out = '0;
  logic          rec_ready = 1'b0;
  logic          rec_valid;
  logic [10:0]   rec_data;
  logic [7:0]    sig;
  logic          busy, done, overflow;

  // CAP_CYC=2 instance
  logic        t_start = 1'b0, t_rdy = 1'b0;
  logic [2:0]  t_stim = '0;
  logic [7:0]  t_dout = '0;
  logic        t_valid, t_busy, t_done, t_over;
  logic [10:0] t_data;
  logic [7:0]  t_sig;

  // CAP_CYC=1 instance
  logic        o_start = 1'b0, o_rdy = 1'b0;
  logic [2:0]  o_stim = '0;
  logic [7:0]  o_dout = '0;
  logic        o_valid, o_busy, o_done, o_over;
  logic [10:0] o_data;
  logic [7:0]  o_sig;

  trojan_resp_capture #(.OUT_W(OW), .STIM_W(SW), .CAP_CYC(CAP), .FIFO_DEPTH(DEPTH)) u_dut (
    .CK(CK), .reset(reset), .start(start), .stim_in(stim_in), .dut_out(dut_out),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data), .sig(sig),
    .busy(busy), .done(done), .overflow(overflow));

  trojan_resp_capture #(.OUT_W(8), .STIM_W(3), .CAP_CYC(2), .FIFO_DEPTH(16)) u_two (
    .CK(CK), .reset(reset), .start(t_start), .stim_in(t_stim), .dut_out(t_dout),
    .rec_valid(t_valid), .rec_ready(t_rdy), .rec_data(t_data), .sig(t_sig),
    .busy(t_busy), .done(t_done), .overflow(t_over));

  trojan_resp_capture #(.OUT_W(8), .STIM_W(3), .CAP_CYC(1), .FIFO_DEPTH(16)) u_one (
    .CK(CK), .reset(reset), .start(o_start), .stim_in(o_stim), .dut_out(o_dout),
    .rec_valid(o_valid), .rec_ready(o_rdy), .rec_data(o_data), .sig(o_sig),
    .busy(o_busy), .done(o_done), .overflow(o_over));

  int n_checks = 0;
  int n_pass   = 0;
  int dut_pops = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: run phase measured in edges since start was accepted,
  // FIFO as a plain queue of expected records.
  bit          m_busy = 0, m_done = 0, m_over = 0;
  int          m_edge = 0;
  logic [7:0]  m_sig  = '0;
  logic [10:0] q[$];

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
    logic [7:0] fb;
    fb = s[7] ? POLY : 8'h00;
    return (s << 1) ^ fb ^ d;
  endfunction

  task automatic model_edge();
    bit was_empty;
    if (reset) begin
      m_busy = 0; m_done = 0; m_over = 0; m_sig = '0; m_edge = 0;
      q.delete();
    end else begin
      was_empty = (q.size() == 0);
      if (!was_empty && rec_ready) q.delete(0);
      if (m_busy) begin
        if (m_edge >= 1 && m_edge <= CAP) begin
          m_sig = misr_step(m_sig, dut_out);
          if (q.size() < DEPTH) q.push_back({stim_in, dut_out});
          else m_over = 1;
        end else if (m_edge > CAP && was_empty) begin
          m_busy = 0;
          m_done = 1;
        end
        m_edge++;
      end else if (start) begin
        m_busy = 1; m_edge = 0; m_sig = '0; m_over = 0; m_done = 0;
      end
    end
  endtask

  task automatic compare();
    check_val("busy", busy, m_busy);
    check_val("done", done, m_done);
    check_val("overflow", overflow, m_over);
    check_val("sig", sig, m_sig);
    check_val("rec_valid", rec_valid, q.size() != 0);
    if (q.size() != 0) check_val("rec_data", rec_data, q[0]);
  endtask

  task automatic tick();
    if (!reset && rec_valid && rec_ready) dut_pops++;
    model_edge();
    @(posedge CK);
    #1;
    compare();
    stim_in = 3'($urandom);
    dut_out = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && !done; i++) tick();
    check_val(tag, done, 1'b1);
  endtask

  int p0;
  int bias;

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    check_val("rst_two_busy", t_busy, 1'b0);
    check_val("rst_one_valid", o_valid, 1'b0);

    // Directed vectors on the 2-sample and 1-sample instances, side by side.
    t_rdy = 1; o_rdy = 1; t_start = 1; o_start = 1;
    o_stim = 3'b101; o_dout = 8'h01; t_stim = 3'b010; t_dout = 8'h80;
    tick();
    t_start = 0; o_start = 0;
    check_val("two_busy", t_busy, 1'b1);
    check_val("one_done_lo", o_done, 1'b0);
    tick();
    check_val("one_settle_norec", o_valid, 1'b0);
    tick();
    check_val("two_rec0", t_data, 11'h280);
    check_val("two_sig0", t_sig, 8'h80);
    check_val("one_rec", o_data, 11'h501);
    check_val("one_sig", o_sig, 8'h01);
    t_stim = 3'b111; t_dout = 8'h00;
    tick();
    check_val("two_rec1", t_data, 11'h700);
    check_val("two_sig1", t_sig, 8'h1D);
    check_val("one_drain_done", o_done, 1'b0);
    check_val("one_drain_busy", o_busy, 1'b1);
    tick();
    check_val("one_done", o_done, 1'b1);
    check_val("one_busy_lo", o_busy, 1'b0);
    check_val("two_empty", t_valid, 1'b0);
    tick();
    check_val("two_done", t_done, 1'b1);
    check_val("two_over", t_over, 1'b0);
    check_val("two_sig_final", t_sig, 8'h1D);

    // Consumer stalled for the whole run: 16 held, 4 dropped.
    start = 1; tick(); start = 0;
    rec_ready = 0;
    repeat (CAP + 1) tick();
    check_val("stall_over", overflow, 1'b1);
    check_val("stall_valid", rec_valid, 1'b1);
    p0 = dut_pops;
    rec_ready = 1;
    wait_done("stall_done");
    check_val("stall_pops", dut_pops - p0, 16);

    // Restart from DONE clears flags; starts during CAPTURE/DRAIN are ignored.
    start = 1; tick(); start = 0;
    check_val("restart_done_clr", done, 1'b0);
    check_val("restart_over_clr", overflow, 1'b0);
    p0 = dut_pops;
    repeat (8) tick();
    start = 1; tick(); start = 0;
    repeat (CAP - 8) tick();
    start = 1; tick(); start = 0;
    wait_done("ign_done");
    check_val("ign_pops", dut_pops - p0, CAP);

    // Fill to full, then pop on the 17th sample edge: no drop.
    rec_ready = 0;
    start = 1; tick(); start = 0;
    repeat (1 + DEPTH) tick();
    p0 = dut_pops;
    rec_ready = 1;
    wait_done("full_pop_done");
    check_val("full_pop_over", overflow, 1'b0);
    check_val("full_pop_pops", dut_pops - p0, CAP);

    // Reset on the 5th capture edge, then a clean run.
    start = 1; tick(); start = 0;
    repeat (5) tick();
    reset = 1; tick(); reset = 0;
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_valid", rec_valid, 1'b0);
    check_val("abort_sig", sig, 8'h00);
    check_val("abort_done", done, 1'b0);
    tick(); tick();
    start = 1; tick(); start = 0;
    wait_done("abort_rerun_done");

    // Randomized runs with varying consumer throughput and stray starts/resets.
    for (int r = 0; r < 25; r++) begin
      bias = $urandom_range(30, 100);
      start = 1; tick(); start = 0;
      for (int i = 0; i < 400; i++) begin
        rec_ready = ($urandom_range(0, 99) < bias);
        start = ($urandom_range(0, 19) == 0);
        reset = ($urandom_range(0, 299) == 0);
        tick();
        reset = 0; start = 0;
        if (!m_busy) break;
      end
      check_val("run_idle", busy, 1'b0);
      rec_ready = 1;
      for (int i = 0; i < 40 && rec_valid; i++) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
